// File: rtl/tube_data_formatter.sv
// rtl/tube_data_formatter.sv - 32-bit binary to 8-digit BCD/hex formatter for the tube display.
// Optional feature macro: PENDING_WR_EN (one-deep pending write slot while a conversion runs).
module tube_data_formatter (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        mode,
    output logic [31:0] show_data,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t      state_q, state_d;
    logic [31:0] bin_q, bin_d;
    logic [39:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] show_q, show_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic [39:0] bcd_adj;
    logic        bcd_adj_unused;

    logic        start_v;
    logic [31:0] start_data;
    logic        start_mode;

`ifdef PENDING_WR_EN
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic        pend_mode_q, pend_mode_d;

    // A held write takes priority over a new strobe in IDLE; the new strobe then refills the slot.
    assign start_v    = pend_v_q | wr_en;
    assign start_data = pend_v_q ? pend_data_q : wr_data;
    assign start_mode = pend_v_q ? pend_mode_q : mode;

    always_comb begin
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        pend_mode_d = pend_mode_q;
        if (state_q == IDLE) begin
            if (pend_v_q) begin
                pend_v_d    = wr_en;
                pend_data_d = wr_en ? wr_data : pend_data_q;
                pend_mode_d = wr_en ? mode : pend_mode_q;
            end
        end else if (wr_en) begin
            pend_v_d    = 1'b1;
            pend_data_d = wr_data;
            pend_mode_d = mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v_q    <= 1'b0;
            pend_data_q <= 32'd0;
            pend_mode_q <= 1'b0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            pend_mode_q <= pend_mode_d;
        end
    end
`else
    assign start_v    = wr_en;
    assign start_data = wr_data;
    assign start_mode = mode;
`endif

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign bcd_adj_unused = bcd_adj[39];

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        show_d  = show_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_v) begin
                    if (start_mode) begin
                        show_d = start_data;
                        ovf_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        bin_d   = start_data;
                        bcd_d   = 40'd0;
                        cnt_d   = 5'd0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[38:0], bin_q[31]};
                bin_d = {bin_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                show_d  = bcd_q[31:0];
                ovf_d   = |bcd_q[39:32];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= 32'd0;
            bcd_q   <= 40'd0;
            cnt_q   <= 5'd0;
            show_q  <= 32'd0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            show_q  <= show_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign show_data = show_q;
    assign ovf       = ovf_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/tube_data_formatter.md
TUBE_DATA_FORMATTER -- requirements
Module: tube_data_formatter

Interface
REQ-001 SHALL have the following ports, one per line: name, direction, width, meaning.
  clk  input  1  system clock, 100 MHz.
  rst  input  1  reset, asynchronous, active-high.
  wr_en  input  1  one-cycle write strobe from the CPU MMIO decode.
  wr_data  input  32  value to be displayed.
  mode  input  1  0 = unsigned decimal (BCD), 1 = hex passthrough; sampled only with an accepted wr_en.
  show_data  output  32  eight 4-bit digits for the tube controller; [3:0] is the rightmost digit.
  busy  output  1  a decimal conversion is in progress.
  done  output  1  one-cycle pulse when show_data has just been updated.
  ovf  output  1  the last displayed decimal value exceeded 99999999.
REQ-002 SHALL use a single clock domain (clk) and asynchronous active-high reset (rst) only.

Function
REQ-003 SHALL implement FSM states IDLE, CONV, LOAD; reset state IDLE.
REQ-004 IDLE, wr_en=1, mode=1: SHALL load show_data <= wr_data, ovf <= 0, and pulse done on the same edge; state stays IDLE; busy stays 0.
REQ-005 IDLE, wr_en=1, mode=0: SHALL capture wr_data into a 32-bit shift register, clear a 40-bit BCD accumulator, and go to CONV (edge E0).
REQ-006 CONV SHALL run double-dabble for exactly 32 cycles (edges E1..E32): add 3 to each BCD nibble >= 5, then shift left one bit, with the binary MSB entering the BCD LSB.
REQ-007 After E32 SHALL go to LOAD; at E33 SHALL set show_data <= BCD[31:0], ovf <= (BCD[39:32] != 0), pulse done, and return to IDLE.
REQ-008 busy SHALL be 1 in every cycle following edges E0..E32 and 0 in the cycle done is high.
REQ-009 show_data SHALL change only at a done edge; no intermediate conversion value SHALL ever appear on it.
REQ-010 Decimal latency from the accepting edge to the show_data update SHALL be exactly 33 cycles.
REQ-011 done SHALL be high for exactly one cycle per completed write.
REQ-012 A write during CONV or LOAD SHALL be handled per REQ-016/REQ-017 and SHALL never disturb the conversion in progress.
REQ-013 Input overflow (value > 99999999) SHALL display the low 8 decimal digits and set ovf; it SHALL NOT saturate.

Reset
REQ-014 On rst=1, SHALL immediately, without a clock edge, set show_data=0, busy=0, done=0, ovf=0, state=IDLE, and clear all shift, BCD, and pending registers.
REQ-015 Reset asserted mid-conversion SHALL abort the conversion; no done pulse SHALL follow deassertion.

Configuration
REQ-016 With PENDING_WR_EN defined: SHALL keep a one-deep pending slot (data and mode) for writes accepted during CONV or LOAD; the latest write SHALL overwrite it; in the cycle after done, the pending entry SHALL start as if written in IDLE, and the slot SHALL then clear.
REQ-017 Without PENDING_WR_EN: wr_en during CONV or LOAD SHALL be ignored, with no side effects.

Verification
REQ-018 Decimal write 32'd12345678 -> after 33 cycles show_data=0x12345678, ovf=0, one done pulse, busy high for 33 cycles.
REQ-019 Decimal 32'hFFFFFFFF (4294967295) -> show_data=0x94967295, ovf=1; decimal 32'd99999999 -> 0x99999999, ovf=0; decimal 32'd100000000 -> 0x00000000, ovf=1.
REQ-020 Hex mode write 0xDEADBEEF in IDLE -> show_data=0xDEADBEEF the next cycle, done pulse, busy never high, ovf=0.
REQ-021 Decimal write 5, then write 7 and write 9 while busy -> with PENDING_WR_EN: show_data=0x00000005, then 0x00000009 and exactly two done pulses; without: only 0x00000005 and one done pulse.
REQ-022 Reset pulse at conversion cycle 10 of decimal 42 -> show_data=0, busy=0 immediately; no done pulse within 40 cycles after release; a fresh write of 42 -> 0x00000042.
